// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
//
// Consumes a byte stream of the form
//   N[15:8] N[7:0] { w[31:24] w[23:16] w[15:8] w[7:0] } x N  [checksum]
// writes each assembled word to instruction memory at consecutive word
// addresses, then releases the processor core from reset. A word count of
// zero or one larger than MAX_WORDS parks the loader in an error state with
// the core held in reset.
//
// Optional feature (compile-time macro IMEM_LOADER_CHKSUM_EN): a trailing
// checksum byte is required. The 8-bit sum of every header and payload byte
// plus the checksum byte must be 0 mod 256, otherwise the loader errors out.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   byte_valid/data      upstream byte stream
//   byte_ready           loader takes a byte when byte_valid && byte_ready
//   im_we/addr/wdata     instruction memory write port (one-cycle strobe)
//   cpu_rst              reset to the core, released once the image is loaded
//   load_done            image loaded, core running
//   load_err             malformed image; sticky until rst
module imem_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef IMEM_LOADER_CHKSUM_EN
    CHK,
`endif
    RUN,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_hi_q, hdr_hi_d;
  logic [15:0] nwords_q, nwords_d;
  logic [15:0] widx_q, widx_d;     // index of the word being assembled
  logic [1:0]  bidx_q, bidx_d;     // byte position within that word
  logic [23:0] word_q, word_d;     // first three bytes of the current word
  logic        we_q, we_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  sum_chk;
`endif

  logic        xfer;
  logic [15:0] n_hdr;

  // rst gates ready combinationally so it is low throughout reset and high
  // in the very first cycle after release.
  assign byte_ready = !rst && (state_q != RUN) && (state_q != ERR);
  assign xfer       = byte_valid && byte_ready;
  assign n_hdr      = {hdr_hi_q, byte_data};

  always_comb begin
    state_d  = state_q;
    hdr_hi_d = hdr_hi_q;
    nwords_d = nwords_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    // load_done lags RUN entry by one cycle so it rises after the last strobe
    done_d   = (state_q == RUN);
`ifdef IMEM_LOADER_CHKSUM_EN
    sum_d    = sum_q;
    sum_chk  = sum_q + byte_data;
    if (xfer && (state_q == HDR_HI || state_q == HDR_LO || state_q == DATA))
      sum_d = sum_chk;
`endif
    case (state_q)
      HDR_HI: if (xfer) begin
        hdr_hi_d = byte_data;
        state_d  = HDR_LO;
      end
      HDR_LO: if (xfer) begin
        if (n_hdr == 16'd0 || {1'b0, n_hdr} > MAX_W) begin
          state_d = ERR;
        end else begin
          nwords_d = n_hdr;
          widx_d   = 16'd0;
          bidx_d   = 2'd0;
          state_d  = DATA;
        end
      end
      DATA: if (xfer) begin
        if (bidx_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = widx_q[9:0];
          wdata_d = {word_q, byte_data};
          widx_d  = widx_q + 16'd1;
          bidx_d  = 2'd0;
          if (widx_q == nwords_q - 16'd1) begin
`ifdef IMEM_LOADER_CHKSUM_EN
            state_d = CHK;
`else
            state_d = RUN;
`endif
          end
        end else begin
          word_d = {word_q[15:0], byte_data};
          bidx_d = bidx_q + 2'd1;
        end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      CHK: if (xfer) begin
        state_d = (sum_chk == 8'd0) ? RUN : ERR;
      end
`endif
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HDR_HI;
      hdr_hi_q <= 8'd0;
      nwords_q <= 16'd0;
      widx_q   <= 16'd0;
      bidx_q   <= 2'd0;
      word_q   <= 24'd0;
      we_q     <= 1'b0;
      addr_q   <= 10'd0;
      wdata_q  <= 32'd0;
      done_q   <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      hdr_hi_q <= hdr_hi_d;
      nwords_q <= nwords_d;
      widx_q   <= widx_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign load_done = done_q;
  assign cpu_rst   = !done_q;
  assign load_err  = (state_q == ERR);

endmodule
